// File: rtl/logic_op_stage.sv
// Flow-controlled bitwise logic stage: evaluates AND/OR/XOR/NOT on accepted
// requests and queues the results in a small FIFO for a back-pressuring consumer.
module logic_op_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [1:0]               Op,
    input  logic [WIDTH-1:0]         X,
    input  logic [WIDTH-1:0]         Y,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [WIDTH-1:0]         Result,
    output logic                     Zero,
    output logic [$clog2(DEPTH):0]   Level,
    output logic [CNTW-1:0]          Op_Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] op_result;
    logic             push;
    logic             pop;

    always_comb begin
        op_result = '0;
        case (op_e'(Op))
            OP_AND:  op_result = X & Y;
            OP_OR:   op_result = X | Y;
            OP_XOR:  op_result = X ^ Y;
            OP_NOT:  op_result = ~X;
            default: op_result = '0;
        endcase
    end

    // Ready depends on occupancy alone; a same-cycle pop never frees a slot early.
    assign In_Ready  = (Level < LW'(DEPTH));
    assign Out_Valid = (Level != '0);
    assign push      = In_Valid && In_Ready;
    assign pop       = Out_Valid && Out_Ready;
    assign Result    = Out_Valid ? mem[rd_ptr] : '0;
    assign Zero      = (Result == '0);

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= op_result;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Level    <= '0;
            Op_Count <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                Op_Count <= Op_Count + CNTW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   Level <= Level + LW'(1);
                2'b01:   Level <= Level - LW'(1);
                default: Level <= Level;
            endcase
        end
    end

endmodule
